verificar_senha_multi: RTL and testbench
========================================

// Module: verificar_senha_multi
// PURPOSE
// - Parametrised successor of the lock's PIN checker: verifies an entered PIN against a master PIN and NUM_PINS user PINs of NUM_DIGITS BCD digits.
// - Scans slots serially under an FSM. Counts consecutive failures and enters a timed lockout after MAX_FAILS failures.
// - Sits between keypad entry and the lock control FSM, which consumes the one-cycle result pulses.
// PARAMETERS
// - NUM_PINS        4    user PIN slots (>=1)
// - NUM_DIGITS      4    BCD digits per PIN (>=1); digit 1 is the LS nibble
// - MAX_FAILS       3    consecutive failures that trigger lockout (>=1)
// - LOCKOUT_CYCLES  1000 cycles spent in LOCKED (>=1)
// PORTS
// - clk              in   1                     clock, rising edge
// - rst              in   1                     asynchronous, active-high reset
// - pin_valid        in   1                     entered PIN offered
// - pin_ready        out  1                     high only in IDLE; accept = pin_valid & pin_ready
// - pin_digits       in   4*NUM_DIGITS          entered PIN
// - master_pin       in   4*NUM_DIGITS          master PIN (slot 0)
// - user_pins        in   4*NUM_DIGITS*NUM_PINS user PIN j at bits [j*4*NUM_DIGITS +: 4*NUM_DIGITS] (slot j+1)
// - user_pin_en      in   NUM_PINS              per-slot active flag; disabled slots never match
// - senha_master     out  1                     pulse: master match
// - senha_padrao     out  1                     pulse: user PIN match
// - senha_fail       out  1                     pulse: no match or invalid digit
// - match_idx        out  $clog2(NUM_PINS+1)    matching slot, valid with the match pulses, else 0
// - senha_ignorada   out  1                     pulse: pin_valid seen while LOCKED
// - bloqueado        out  1                     high throughout LOCKED
// - fail_count       out  $clog2(MAX_FAILS+1)   current consecutive-failure count
// BEHAVIOUR
// - Reset (async, any state, including mid-scan): state IDLE; every output 0 except pin_ready=1; counters and captured PIN cleared.
// - The clock and reset are a single domain: one clock, asynchronous active-high reset.
// - FSM states: IDLE, CHECK, SCAN, LOCKED.
//   - IDLE: on accept at edge E0, capture pin_digits, idx<=0, go to CHECK. pin_valid without ready is dropped silently, except in LOCKED.
//   - CHECK, one cycle: if any captured digit >9, fail at E0+2. Otherwise go to SCAN.
//   - SCAN: compares slot idx per cycle; slot 0 is master, slot k is user PIN k-1 qualified by user_pin_en[k-1].
//     - First match at slot k: result registered at E0+k+2, then back to IDLE.
//     - No match after slot NUM_PINS: fail registered at E0+NUM_PINS+2.
//   - Master has priority because slot 0 is scanned first. A duplicate user PIN reports the lowest slot.
// - master_pin, user_pins and user_pin_en are sampled live. The source holds them stable while pin_ready=0.
// - Result pulses (senha_*) last exactly one cycle and are mutually exclusive.
// - fail_count:
//   - Any match clears it to 0.
//   - A fail increments it. When the increment reaches MAX_FAILS, senha_fail still pulses and the FSM enters LOCKED (not IDLE) on the same edge.
// - LOCKED:
//   - bloqueado=1, pin_ready=0; lockout timer loaded with LOCKOUT_CYCLES-1 and decremented each cycle.
//   - At timer 0: go to IDLE, clear fail_count, bloqueado<=0. LOCKED lasts exactly LOCKOUT_CYCLES cycles.
//   - Each cycle with pin_valid=1 pulses senha_ignorada for that cycle (registered, +1 cycle). The attempt is discarded.
// - Counter widths are derived by $clog2. fail_count saturates and never wraps.
// STRUCTURE
// - Shared package lock_pkg:
//   - DIGIT_W=4 and typedef bcd_t.
//   - Enum verif_state_t {IDLE, CHECK, SCAN, LOCKED}.
//   - Function bcd_valid(vec) for the digit >9 check.
// - One sub-module pin_slot_compare (combinational):
//   - Inputs: entered PIN, slot PIN, enable.
//   - Output: match.
//   - Muxed by idx inside this block.
// TESTING
// - Defaults; master=1234, pins={5678,0000,1111,2222}, en=4'b1111. Enter 1234 at E0 -> senha_master at E0+2, match_idx=0.
// - Enter 1111 -> senha_padrao at E0+5, match_idx=3, fail_count 0. Then clear en[2] and re-enter 1111 -> senha_fail at E0+6.
// - Enter 12A4 (digit 0xA) -> senha_fail at E0+2, no SCAN cycles. fail_count increments.
// - Three wrong PINs (9999) -> third senha_fail and bloqueado rise together.
//   - pin_valid held in LOCKED -> senha_ignorada every cycle.
//   - After exactly 1000 cycles: bloqueado=0, fail_count=0, pin_ready=1.
// - Two fails, then a correct user PIN -> fail_count returns to 0. Two more fails do not lock.
// - Assert rst asynchronously mid-SCAN and mid-LOCKED -> outputs 0, pin_ready=1 immediately. The next entry behaves as if from a fresh reset.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock's PIN verification path: BCD digit type,
// verifier FSM states and the BCD digit validity helper.
package lock_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SCAN   = 2'd2,
        LOCKED = 2'd3
    } verif_state_t;

    // A nibble is a legal BCD digit only in the range 0..9.
    function automatic logic bcd_valid(input bcd_t vec);
        return (vec <= 4'd9);
    endfunction

endpackage

// File: rtl/pin_slot_compare.sv
// Combinational comparison of the captured PIN against one slot PIN;
// a disabled slot never matches.
module pin_slot_compare
    import lock_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [DIGIT_W*NUM_DIGITS-1:0] entered,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] slot_pin,
    input  logic                          enable,
    output logic                          match
);

    assign match = enable && (entered == slot_pin);

endmodule

// File: rtl/verificar_senha_multi.sv
// PIN checker: scans the master PIN and NUM_PINS user PINs one slot per cycle,
// counts consecutive failures and holds a timed lockout after MAX_FAILS of them.
module verificar_senha_multi
    import lock_pkg::*;
#(
    parameter int NUM_PINS       = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pin_valid,
    output logic                                   pin_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]          pin_digits,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]          master_pin,
    input  logic [DIGIT_W*NUM_DIGITS*NUM_PINS-1:0] user_pins,
    input  logic [NUM_PINS-1:0]                    user_pin_en,
    output logic                                   senha_master,
    output logic                                   senha_padrao,
    output logic                                   senha_fail,
    output logic [$clog2(NUM_PINS+1)-1:0]          match_idx,
    output logic                                   senha_ignorada,
    output logic                                   bloqueado,
    output logic [$clog2(MAX_FAILS+1)-1:0]         fail_count
);

    localparam int PIN_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_PINS + 1);
    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    verif_state_t      state_r;
    logic [PIN_W-1:0]  pin_r;
    logic [IDX_W-1:0]  idx_r;
    logic              bad_r;
    logic [TMR_W-1:0]  timer_r;

    logic              pin_ok_s;
    logic [PIN_W-1:0]  slot_pin_s;
    logic              slot_en_s;
    logic              slot_match_s;
    logic [FC_W-1:0]   fc_inc_s;
    logic              lock_s;

    // Every captured nibble must be a legal BCD digit.
    always_comb begin
        pin_ok_s = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            pin_ok_s = pin_ok_s & bcd_valid(pin_r[d*DIGIT_W +: DIGIT_W]);
        end
    end

    // Slot 0 is the master PIN (always enabled); slot k is user PIN k-1.
    always_comb begin
        slot_pin_s = master_pin;
        slot_en_s  = 1'b1;
        for (int j = 0; j < NUM_PINS; j++) begin
            slot_pin_s = (idx_r == IDX_W'(j + 1)) ? user_pins[j*PIN_W +: PIN_W] : slot_pin_s;
            slot_en_s  = (idx_r == IDX_W'(j + 1)) ? user_pin_en[j] : slot_en_s;
        end
    end

    pin_slot_compare #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_slot_compare (
        .entered  (pin_r),
        .slot_pin (slot_pin_s),
        .enable   (slot_en_s),
        .match    (slot_match_s)
    );

    assign fc_inc_s = (fail_count == FC_MAX) ? FC_MAX : (fail_count + FC_W'(1));
    assign lock_s   = (fc_inc_s == FC_MAX);

    // Verifier FSM with registered result pulses, failure counter and lockout timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            pin_r          <= {PIN_W{1'b0}};
            idx_r          <= {IDX_W{1'b0}};
            bad_r          <= 1'b0;
            timer_r        <= {TMR_W{1'b0}};
            pin_ready      <= 1'b1;
            senha_master   <= 1'b0;
            senha_padrao   <= 1'b0;
            senha_fail     <= 1'b0;
            match_idx      <= {IDX_W{1'b0}};
            senha_ignorada <= 1'b0;
            bloqueado      <= 1'b0;
            fail_count     <= {FC_W{1'b0}};
        end else begin
            senha_master   <= 1'b0;
            senha_padrao   <= 1'b0;
            senha_fail     <= 1'b0;
            match_idx      <= {IDX_W{1'b0}};
            senha_ignorada <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pin_valid && pin_ready) begin
                        pin_r     <= pin_digits;
                        idx_r     <= {IDX_W{1'b0}};
                        pin_ready <= 1'b0;
                        state_r   <= CHECK;
                    end
                end
                CHECK: begin
                    bad_r   <= !pin_ok_s;
                    idx_r   <= {IDX_W{1'b0}};
                    state_r <= SCAN;
                end
                SCAN: begin
                    // An invalid PIN skips comparison so its fail lands with slot-0 timing.
                    if (bad_r || (!slot_match_s && (idx_r == LAST_IDX))) begin
                        senha_fail <= 1'b1;
                        fail_count <= fc_inc_s;
                        if (lock_s) begin
                            state_r   <= LOCKED;
                            bloqueado <= 1'b1;
                            timer_r   <= TMR_LOAD;
                        end else begin
                            state_r   <= IDLE;
                            pin_ready <= 1'b1;
                        end
                    end else if (slot_match_s) begin
                        senha_master <= (idx_r == {IDX_W{1'b0}});
                        senha_padrao <= (idx_r != {IDX_W{1'b0}});
                        match_idx    <= idx_r;
                        fail_count   <= {FC_W{1'b0}};
                        state_r      <= IDLE;
                        pin_ready    <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                LOCKED: begin
                    senha_ignorada <= pin_valid;
                    if (timer_r == {TMR_W{1'b0}}) begin
                        state_r    <= IDLE;
                        bloqueado  <= 1'b0;
                        fail_count <= {FC_W{1'b0}};
                        pin_ready  <= 1'b1;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bloqueado <= 1'b0;
                    pin_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verificar_senha_multi.sv
// Self-checking bench for verificar_senha_multi: result pulses are predicted by a
// small PIN model into a scoreboard queue and matched against the DUT cycle by cycle.
module tb_verificar_senha_multi;

    localparam int NP = 4;
    localparam int MF = 3;
    localparam int LC = 1000;
    localparam logic [10:0] RST_VEC = 11'b100_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pin_valid = 1'b0;
    logic [15:0] pin_digits = 16'h0000;
    logic [15:0] master_pin = 16'h1234;
    logic [63:0] user_pins = {16'h2222, 16'h1111, 16'h0000, 16'h5678};
    logic [3:0]  user_pin_en = 4'b1111;
    logic        pin_ready, senha_master, senha_padrao, senha_fail;
    logic        senha_ignorada, bloqueado;
    logic [2:0]  match_idx;
    logic [1:0]  fail_count;

    verificar_senha_multi dut (
        .clk            (clk),
        .rst            (rst),
        .pin_valid      (pin_valid),
        .pin_ready      (pin_ready),
        .pin_digits     (pin_digits),
        .master_pin     (master_pin),
        .user_pins      (user_pins),
        .user_pin_en    (user_pin_en),
        .senha_master   (senha_master),
        .senha_padrao   (senha_padrao),
        .senha_fail     (senha_fail),
        .match_idx      (match_idx),
        .senha_ignorada (senha_ignorada),
        .bloqueado      (bloqueado),
        .fail_count     (fail_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int model_fc = 0;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } exp_t;
    exp_t sb[$];

    // Reference: -2 invalid digit, -1 no match, else first matching slot.
    function automatic int model_slot(input logic [15:0] p);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            nib = p[d*4 +: 4];
            if (nib > 4'd9) return -2;
        end
        if (p == master_pin) return 0;
        for (int j = 0; j < NP; j++) begin
            if (user_pin_en[j] && (p == user_pins[j*16 +: 16])) return j + 1;
        end
        return -1;
    endfunction

    task automatic monitor();
        exp_t e;
        logic [7:0] obs;
        forever begin
            @(negedge clk);
            if (rst == 1'b0) begin
                obs = {senha_master, senha_padrao, senha_fail, match_idx, fail_count};
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    checks++;
                    if (obs !== e.v) begin
                        errors++;
                        $display("FAIL result cyc=%0d got {m,p,f,idx,fc}=%b want %b", cyc, obs, e.v);
                    end
                end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_result cyc=%0d got %b want %b at cyc %0d", cyc, obs, e.v, e.cyc);
                end else if (senha_master || senha_padrao || senha_fail) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got %b want no pulse", cyc, obs);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int bound;
        bound = 0;
        while (sb.size() != 0 && bound < 50) begin
            @(negedge clk);
            #1;
            bound++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic enter_pin(input logic [15:0] p, input bit wait_result);
        int   slot, bound, e0, newfc;
        exp_t e;
        bound = 0;
        while (pin_ready !== 1'b1 && bound < 2000) begin
            @(negedge clk);
            #1;
            bound++;
        end
        if (pin_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout pin_ready=%b want 1", pin_ready);
        end else begin
            pin_digits = p;
            pin_valid  = 1'b1;
            @(posedge clk);
            #1;
            pin_valid = 1'b0;
            e0 = cyc;
            slot = model_slot(p);
            if (slot >= 0) begin
                e.cyc    = e0 + 2 + slot;
                e.v      = {(slot == 0), (slot != 0), 1'b0, 3'(slot), 2'b00};
                model_fc = 0;
            end else begin
                newfc    = (model_fc < MF) ? model_fc + 1 : MF;
                e.cyc    = (slot == -2) ? e0 + 2 : e0 + 2 + NP;
                e.v      = {3'b001, 3'b000, 2'(newfc)};
                model_fc = newfc;
            end
            sb.push_back(e);
            if (wait_result) wait_drain();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_fc = 0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({pin_ready, senha_master, senha_padrao, senha_fail, match_idx,
             senha_ignorada, bloqueado, fail_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", {pin_ready, senha_master, senha_padrao,
                     senha_fail, match_idx, senha_ignorada, bloqueado, fail_count}, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_master();
        enter_pin(16'h1234, 1'b1);
        checks++;
        if (pin_ready !== 1'b1) begin
            errors++;
            $display("FAIL master_ready got %b want 1", pin_ready);
        end
    endtask

    task automatic test_user_slots();
        enter_pin(16'h1111, 1'b1);
        checks++;
        if (fail_count !== 2'd0) begin
            errors++;
            $display("FAIL user_fc got %0d want 0", fail_count);
        end
        user_pin_en = 4'b1011;
        enter_pin(16'h1111, 1'b1);
        user_pin_en = 4'b1111;
        enter_pin(16'h5678, 1'b1);
        enter_pin(16'h0000, 1'b1);
        enter_pin(16'h2222, 1'b1);
        user_pins[15:0] = 16'h1234;
        enter_pin(16'h1234, 1'b1);
        user_pins[15:0]  = 16'h5678;
        user_pins[63:48] = 16'h0000;
        enter_pin(16'h0000, 1'b1);
        user_pins[63:48] = 16'h2222;
    endtask

    task automatic test_invalid();
        do_reset();
        enter_pin(16'h12A4, 1'b1);
        checks++;
        if (fail_count !== 2'd1) begin
            errors++;
            $display("FAIL invalid_fc got %0d want 1", fail_count);
        end
        enter_pin(16'hF000, 1'b1);
        enter_pin(16'h1234, 1'b1);
    endtask

    task automatic test_busy_drop();
        enter_pin(16'h2222, 1'b0);
        pin_digits = 16'h1234;
        pin_valid  = 1'b1;
        repeat (3) @(negedge clk);
        pin_valid = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if ({pin_ready, senha_ignorada} !== 2'b10) begin
            errors++;
            $display("FAIL busy_drop {ready,ign} got %b want 10", {pin_ready, senha_ignorada});
        end
    endtask

    task automatic test_lockout();
        int f;
        do_reset();
        repeat (3) enter_pin(16'h9999, 1'b1);
        f = cyc;
        checks++;
        if ({bloqueado, pin_ready, fail_count} !== 4'b1011) begin
            errors++;
            $display("FAIL lock_entry {blq,ready,fc} got %b want 1011", {bloqueado, pin_ready, fail_count});
        end
        pin_digits = 16'h1234;
        pin_valid  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (senha_ignorada !== 1'b1) begin
                errors++;
                $display("FAIL ignorada cyc=%0d got %b want 1", cyc, senha_ignorada);
            end
        end
        pin_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (senha_ignorada !== 1'b0) begin
            errors++;
            $display("FAIL ignorada_idle got %b want 0", senha_ignorada);
        end
        repeat (f + LC - 1 - cyc) @(negedge clk);
        #1;
        checks++;
        if ({bloqueado, pin_ready} !== 2'b10) begin
            errors++;
            $display("FAIL lock_last_cycle {blq,ready} got %b want 10", {bloqueado, pin_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bloqueado, pin_ready, fail_count} !== 4'b0100) begin
            errors++;
            $display("FAIL lock_exit {blq,ready,fc} got %b want 0100", {bloqueado, pin_ready, fail_count});
        end
        model_fc = 0;
        enter_pin(16'h1234, 1'b1);
    endtask

    task automatic test_fail_clear();
        do_reset();
        repeat (2) enter_pin(16'h9999, 1'b1);
        enter_pin(16'h5678, 1'b1);
        checks++;
        if (fail_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_fc got %0d want 0", fail_count);
        end
        repeat (2) enter_pin(16'h9999, 1'b1);
        checks++;
        if ({bloqueado, pin_ready, fail_count} !== 4'b0110) begin
            errors++;
            $display("FAIL no_lock {blq,ready,fc} got %b want 0110", {bloqueado, pin_ready, fail_count});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enter_pin(16'h9999, 1'b1);
        enter_pin(16'h2222, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        sb.delete();
        rst = 1'b1;
        #1;
        checks++;
        if ({pin_ready, senha_master, senha_padrao, senha_fail, match_idx,
             senha_ignorada, bloqueado, fail_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid_scan got %b want %b", {pin_ready, senha_master, senha_padrao,
                     senha_fail, match_idx, senha_ignorada, bloqueado, fail_count}, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        model_fc = 0;
        #1;
        enter_pin(16'h1234, 1'b1);
        repeat (3) enter_pin(16'h9999, 1'b1);
        repeat (10) @(negedge clk);
        #2;
        sb.delete();
        rst = 1'b1;
        #1;
        checks++;
        if ({pin_ready, senha_master, senha_padrao, senha_fail, match_idx,
             senha_ignorada, bloqueado, fail_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid_lock got %b want %b", {pin_ready, senha_master, senha_padrao,
                     senha_fail, match_idx, senha_ignorada, bloqueado, fail_count}, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        model_fc = 0;
        #1;
        enter_pin(16'h1111, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_master();
        test_user_slots();
        test_invalid();
        test_busy_drop();
        test_lockout();
        test_fail_clear();
        test_async_reset();
        repeat (5) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
